// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its neighbours.
// Holds the fetch/loader state encoding and the compressed no-op encoding.
// The no-op fills cleared memory and stands in for faulted fetch data.
// Decode reuses the same constant.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_READY,
    ST_LOAD
  } imem_state_t;

  // c.nop encoding
  localparam logic [15:0] CNOP = 16'h0001;

endpackage

// File: rtl/imem_fetch_loader_if.sv
// Bundle of the fetch request/response channel and the program loader channel.
// master: the PC/fetch stage plus the loader (testbench or boot controller).
// slave : the instruction memory.
// Signals:
//   req_valid/req_ready/req_addr  fetch request (byte address)
//   rsp_valid/rsp_ready/rsp_data/rsp_fault  fetch response
//   ld_start/ld_base  begin a load at a byte base address
//   ld_valid/ld_ready/ld_data/ld_last  load word stream
//   ld_ovf  sticky out-of-range load indication
//   busy  memory is clearing or loading
interface imem_fetch_loader_if #(
  parameter int IW = 16,
  parameter int AW = 16
);

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_data;
  logic          rsp_fault;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ovf;
  logic          busy;

  modport master (
    output req_valid, req_addr, rsp_ready,
    output ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  req_ready, rsp_valid, rsp_data, rsp_fault,
    input  ld_ready, ld_ovf, busy
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  ld_start, ld_base, ld_valid, ld_data, ld_last,
    output req_ready, rsp_valid, rsp_data, rsp_fault,
    output ld_ready, ld_ovf, busy
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x IW storage with one write port and one synchronous read port.
// The storage is deliberately not reset.
// rdata only changes on a cycle with re set, so it holds the last fetched
// word while a response waits for its consumer.
// Ports: clk, we/waddr/wdata write port, re/raddr read port, rdata read data.
module imem_array #(
  parameter int IW    = 16,
  parameter int DEPTH = 64,
  localparam int AWORD = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AWORD-1:0] waddr,
  input  logic [IW-1:0]    wdata,
  input  logic             re,
  input  logic [AWORD-1:0] raddr,
  output logic [IW-1:0]    rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_loader.sv
// Loadable instruction memory with a valid/ready fetch port.
// After reset the whole array is filled with FILL_WORD, one word per cycle.
// While that runs, fetches and loads are held off.
// In READY, fetches are served with one cycle of latency through a
// single-entry response register.
// A load pulse switches to LOAD, where a word stream is written from a byte
// base address. Words that fall beyond DEPTH are dropped and flagged on ld_ovf.
// Ports: clk, rst (async, active-high), bus (imem_fetch_loader_if.slave).
module imem_fetch_loader
  import imem_pkg::*;
#(
  parameter int          IW        = 16,
  parameter int          DEPTH     = 64,
  parameter int          AW        = 16,
  parameter logic [IW-1:0] FILL_WORD = IW'(CNOP)
) (
  input  logic clk,
  input  logic rst,
  imem_fetch_loader_if.slave bus
);

  localparam int AWORD = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  imem_state_t   state;
  logic [AWORD-1:0] cnt;
  logic [AW-2:0] ptr;
  logic          rsp_valid_q;
  logic          rsp_fault_q;
  logic          rsp_mem_q;
  logic          ld_ovf_q;

  logic          req_ready_c;
  logic          accept;
  logic [AW-2:0] idx;
  logic          fault_c;
  logic          ptr_in_range;
  logic          we;
  logic [AWORD-1:0] waddr;
  logic [IW-1:0] wdata;
  logic [IW-1:0] rdata;
  logic          unused_base_lsb;

  assign idx          = bus.req_addr[AW-1:1];
  assign fault_c      = bus.req_addr[0] | ({1'b0, idx} >= DEPTH_W);
  assign ptr_in_range = ({1'b0, ptr} < DEPTH_W);

  // A load request wins over a fetch in the same cycle.
  assign req_ready_c = (state == ST_READY) && !bus.ld_start &&
                       (!rsp_valid_q || bus.rsp_ready);
  assign accept      = bus.req_valid && req_ready_c;

  // Bit 0 of the load base is a byte offset inside a word and carries no meaning.
  assign unused_base_lsb = bus.ld_base[0];

  // Write port is shared between the clear sweep and the loader stream.
  always_comb begin
    we    = 1'b0;
    waddr = cnt;
    wdata = FILL_WORD;
    if (state == ST_CLEAR) begin
      we = 1'b1;
    end else if (state == ST_LOAD) begin
      we    = bus.ld_valid && ptr_in_range;
      waddr = ptr[AWORD-1:0];
      wdata = bus.ld_data;
    end
  end

  imem_array #(
    .IW   (IW),
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (accept),
    .raddr(idx[AWORD-1:0]),
    .rdata(rdata)
  );

  // Control FSM, load pointer and response register. A pending response
  // keeps draining in any state because only its consumer can retire it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_CLEAR;
      cnt         <= '0;
      ptr         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_mem_q   <= 1'b0;
      ld_ovf_q    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + AWORD'(1);
          if (cnt == AWORD'(DEPTH - 1)) state <= ST_READY;
        end
        ST_READY: begin
          if (bus.ld_start) begin
            ptr      <= bus.ld_base[AW-1:1];
            ld_ovf_q <= 1'b0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.ld_valid) begin
            if (!ptr_in_range) ld_ovf_q <= 1'b1;
            ptr <= ptr + 1'b1;
            if (bus.ld_last) state <= ST_READY;
          end
        end
        default: state <= ST_CLEAR;
      endcase

      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_fault_q <= fault_c;
        rsp_mem_q   <= !fault_c;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Memory data is only selected for a good fetch. Before any fetch the
  // data reads as zero, because the array output is unknown until a read.
  assign bus.rsp_data  = rsp_mem_q ? rdata : (rsp_fault_q ? FILL_WORD : '0);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.req_ready = req_ready_c;
  assign bus.ld_ready  = (state == ST_LOAD);
  assign bus.ld_ovf    = ld_ovf_q;
  assign bus.busy      = (state != ST_READY);

endmodule

// File: tb/tb_imem_fetch_loader.sv
// Directed testbench for imem_fetch_loader with hand-computed expectations.
module tb_imem_fetch_loader;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  imem_fetch_loader_if #(.IW(16), .AW(16)) bus ();

  imem_fetch_loader #(
    .IW       (16),
    .DEPTH    (64),
    .AW       (16),
    .FILL_WORD(16'h0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 2 time units past the active edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Issue one fetch with the consumer ready and capture the response.
  task automatic fetch(input logic [15:0] a, output logic [15:0] d,
                       output logic f, output logic v);
    int n;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.rsp_ready = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      cyc();
      #1;
      n++;
    end
    tests_run++;
    if (n >= 100) begin
      tests_failed++;
      $display("[TB] FAIL fetch_timeout addr=%h: req_ready never rose", a);
    end
    cyc();
    bus.req_valid = 1'b0;
    #1;
    v = bus.rsp_valid;
    d = bus.rsp_data;
    f = bus.rsp_fault;
    cyc();
  endtask

  task automatic load_start(input logic [15:0] base);
    bus.ld_base  = base;
    bus.ld_start = 1'b1;
    cyc();
    bus.ld_start = 1'b0;
  endtask

  task automatic load_beat(input logic [15:0] data, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = data;
    bus.ld_last  = last;
    cyc();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.ld_ready, bus.ld_ovf, bus.busy} !== 6'b000001) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got rr=%b rv=%b rf=%b lr=%b ovf=%b busy=%b, expected 0 0 0 0 0 1",
               bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.ld_ready, bus.ld_ovf, bus.busy);
    end
    tests_run++;
    if (bus.rsp_data !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp_data: got %h expected 0000", bus.rsp_data);
    end
  endtask

  // Clear sweep: exactly 64 cycles of busy with fetches refused.
  task automatic test_clear(input string tag);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0000;
    bus.rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      tests_run++;
      if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s_clear_cycle%0d: busy=%b req_ready=%b, expected 1 0",
                 tag, i, bus.busy, bus.req_ready);
      end
      cyc();
    end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_clear_done: busy=%b req_ready=%b, expected 0 1",
               tag, bus.busy, bus.req_ready);
    end
    cyc();
    bus.req_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0001 || bus.rsp_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_first_fetch: v=%b d=%h f=%b, expected 1 0001 0",
               tag, bus.rsp_valid, bus.rsp_data, bus.rsp_fault);
    end
    cyc();
  endtask

  task automatic test_load();
    logic [15:0] d;
    logic f, v;
    logic [15:0] exp_d [4] = '{16'hA001, 16'hA002, 16'hA003, 16'h0001};
    bus.ld_base   = 16'h0010;
    bus.ld_start  = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0000;
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_start_priority: req_ready=%b expected 0", bus.req_ready);
    end
    cyc();
    bus.ld_start  = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.ld_ready !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load_enter: rsp_valid=%b ld_ready=%b busy=%b, expected 0 1 1",
               bus.rsp_valid, bus.ld_ready, bus.busy);
    end
    load_beat(16'hA001, 1'b0);
    load_beat(16'hA002, 1'b0);
    load_beat(16'hA003, 1'b1);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b0 || bus.ld_ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_exit: busy=%b ld_ready=%b ovf=%b, expected 0 0 0",
               bus.busy, bus.ld_ready, bus.ld_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      fetch(16'h0010 + 16'(2 * i), d, f, v);
      tests_run++;
      if (v !== 1'b1 || d !== exp_d[i] || f !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL load_readback%0d: v=%b d=%h f=%b, expected 1 %h 0",
                 i, v, d, f, exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [4] = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
    load_start(16'h0000);
    for (int i = 0; i < 4; i++) load_beat(exp_d[i], i == 3);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (bus.req_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL b2b_ready%0d: req_ready=%b expected 1", i, bus.req_ready);
      end
      cyc();
      if (i < 3) bus.req_addr = 16'(2 * (i + 1));
      else bus.req_valid = 1'b0;
      #1;
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d[i]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_rsp%0d: v=%b d=%h, expected 1 %h", i, bus.rsp_valid, bus.rsp_data, exp_d[i]);
      end
    end
    cyc();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_drain: rsp_valid=%b expected 0", bus.rsp_valid);
    end
    // Stall: response for addr 4 held while consumer is not ready.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0004;
    bus.rsp_ready = 1'b0;
    cyc();
    bus.req_addr = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hB002 || bus.req_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold%0d: v=%b d=%h req_ready=%b, expected 1 B002 0",
                 i, bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_release_ready: req_ready=%b expected 1", bus.req_ready);
    end
    cyc();
    bus.req_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hB003) begin
      tests_failed++;
      $display("[TB] FAIL stall_next: v=%b d=%h, expected 1 B003", bus.rsp_valid, bus.rsp_data);
    end
    cyc();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_drain: rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_fault();
    logic [15:0] d;
    logic f, v;
    logic [15:0] addrs [3] = '{16'h0003, 16'h0080, 16'h007E};
    logic        exp_f [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], d, f, v);
      tests_run++;
      if (v !== 1'b1 || f !== exp_f[i] || d !== 16'h0001) begin
        tests_failed++;
        $display("[TB] FAIL fault_addr_%h: v=%b f=%b d=%h, expected 1 %b 0001",
                 addrs[i], v, f, d, exp_f[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    logic f, v;
    logic exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    load_start(16'h007C);
    for (int i = 0; i < 4; i++) begin
      load_beat(16'hC000 + 16'(i), i == 3);
      tests_run++;
      if (bus.ld_ovf !== exp_ovf[i]) begin
        tests_failed++;
        $display("[TB] FAIL ovf_beat%0d: ld_ovf=%b expected %b", i, bus.ld_ovf, exp_ovf[i]);
      end
    end
    fetch(16'h007C, d, f, v);
    tests_run++;
    if (v !== 1'b1 || d !== 16'hC000 || f !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_word62: v=%b d=%h f=%b, expected 1 C000 0", v, d, f);
    end
    fetch(16'h007E, d, f, v);
    tests_run++;
    if (v !== 1'b1 || d !== 16'hC001 || f !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_word63: v=%b d=%h f=%b, expected 1 C001 0", v, d, f);
    end
    load_start(16'h0020);
    tests_run++;
    if (bus.ld_ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_cleared: ld_ovf=%b expected 0", bus.ld_ovf);
    end
    load_beat(16'hD000, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] d;
    logic f, v;
    load_start(16'h0040);
    load_beat(16'hE000, 1'b0);
    load_beat(16'hE001, 1'b0);
    rst = 1'b1;
    #1;
    test_reset();
    cyc();
    rst = 1'b0;
    test_clear("rerun");
    fetch(16'h0040, d, f, v);
    tests_run++;
    if (v !== 1'b1 || d !== 16'h0001 || f !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_load_word32: v=%b d=%h f=%b, expected 1 0001 0", v, d, f);
    end
    fetch(16'h0042, d, f, v);
    tests_run++;
    if (v !== 1'b1 || d !== 16'h0001 || f !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_load_word33: v=%b d=%h f=%b, expected 1 0001 0", v, d, f);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    bus.ld_start  = 1'b0;
    bus.ld_base   = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    repeat (2) cyc();
    test_reset();
    rst = 1'b0;
    test_clear("boot");
    test_load();
    test_back_to_back();
    test_fault();
    test_overflow();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_fetch_loader.md
Name: imem_fetch_loader

Overview:
- Parametrised successor to the fixed 16-bit instruction ROM: a word-organised instruction memory with a loadable program image, a valid/ready fetch port and fault reporting.
- Sits between the PC/fetch stage and decode. A streaming loader port (testbench or boot controller) writes the program at run time instead of hard-coded contents.
- After reset, a hardware clear sequence fills memory with a configurable fill word before fetches are accepted.

Parameters:
- IW, 16, instruction/word width in bits.
- DEPTH, 64, number of IW-bit words (power of 2, >= 4).
- AW, 16, byte-address width of fetch and load addresses.
- FILL_WORD, 16'h0001, value written to every word during clear (c.nop).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when req_valid & req_ready.
- req_addr  in  AW  fetch byte address; word index = req_addr[AW-1:1].
- rsp_valid  out  1  fetch response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  IW  fetched word.
- rsp_fault  out  1  misaligned or out-of-range fetch.
- ld_start  in  1  pulse: begin program load at ld_base.
- ld_base  in  AW  byte base address of load (bit 0 ignored).
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted when ld_valid & ld_ready.
- ld_data  in  IW  load word.
- ld_last  in  1  marks final load word.
- ld_ovf  out  1  sticky: a load word fell outside DEPTH.
- busy  out  1  high in CLEAR or LOAD.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_fault=0, ld_ready=0, ld_ovf=0, busy=1, state=CLEAR, clear counter=0. The array itself is not reset.
- FSM states: CLEAR, READY, LOAD.
- CLEAR: write FILL_WORD to word[cnt] once per cycle; cnt counts 0..DEPTH-1, then go to READY. Takes exactly DEPTH cycles after rst deasserts. req_ready=0, ld_ready=0.
- READY:
  - req_ready = !rsp_valid | rsp_ready (single-entry output register; full throughput when the consumer is always ready).
  - Accepted request: rsp_valid=1 on the next edge. Latency is 1 cycle.
  - Normal fetch: rsp_data = word[req_addr[AW-1:1]], rsp_fault=0.
  - Fault condition: req_addr[0]=1, or word index >= DEPTH. Then rsp_fault=1 and rsp_data=FILL_WORD.
  - rsp_valid/rsp_data/rsp_fault hold stable until rsp_ready. On rsp_ready with no new accept, rsp_valid drops.
- ld_start:
  - Sampled only in READY; ignored in CLEAR and LOAD.
  - Priority over a same-cycle req_valid: req_ready is forced to 0 that cycle.
  - Any pending response stays valid and drains normally.
  - Latches ptr=ld_base[AW-1:1], clears ld_ovf, moves to LOAD.
- LOAD:
  - req_ready=0, ld_ready=1.
  - Each ld_valid beat writes ld_data to word[ptr] if ptr < DEPTH; otherwise the write is dropped and ld_ovf is set. ptr then increments.
  - ptr wraps at 2^(AW-1), not at DEPTH.
  - A beat with ld_last returns to READY on the next edge.
- Read-during-write: not possible, because fetches are blocked in LOAD.
- rst asserted mid-CLEAR or mid-LOAD: immediate return to reset values. Memory contents are undefined until the following CLEAR completes.
- busy = (state != READY).

Decomposition:
- Shared package imem_pkg: state encoding (CLEAR/READY/LOAD) and the default c.nop constant 16'h0001, reused by decode.
- One natural sub-module: imem_array (single write port, synchronous read, DEPTH x IW, no reset). The FSM, pointer and response register stay in imem_fetch_loader.

Test Plan:
- Release rst, hold req_valid=1 addr 0 -> req_ready=0 for 64 cycles, busy falls at cycle 64, first response rsp_data=16'h0001, rsp_fault=0.
- ld_start base 0x0010, stream 16'hA001, 16'hA002, 16'hA003 (last) -> fetches of 0x10/0x12/0x14 return those words; 0x16 returns 16'h0001.
- Back-to-back fetches 0,2,4,6 with rsp_ready=1 -> one response per cycle, 1-cycle latency; drop rsp_ready for 3 cycles -> rsp_data held, req_ready=0.
- Fetch addr 0x0003 -> rsp_fault=1, rsp_data=16'h0001; fetch 0x0080 (index 64) -> rsp_fault=1.
- Load base 0x007C, 4 words -> words 62,63 written, ld_ovf=1 after third beat; next ld_start clears ld_ovf.
- Assert rst during LOAD after 2 beats -> outputs return to reset values, CLEAR reruns for 64 cycles, fetch of the load address returns 16'h0001.
